// File: rtl/uart_reg_bridge_pkg.sv
// Shared encodings for the UART register bridge: FSM states, command codes,
// response status codes and the frame status evaluation.
package uart_reg_bridge_pkg;

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_ADDR    = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_SUM     = 3'd4;
  localparam logic [2:0] ST_EXEC    = 3'd5;
  localparam logic [2:0] ST_RD_WAIT = 3'd6;
  localparam logic [2:0] ST_RESP    = 3'd7;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef logic [7:0] status_t;
  localparam status_t STATUS_OK      = 8'h00;
  localparam status_t STATUS_CSUM    = 8'h01;
  localparam status_t STATUS_BAD_CMD = 8'h02;
  localparam status_t STATUS_PARITY  = 8'h03;

  // Parity outranks checksum, which outranks an unknown command.
  function automatic status_t frame_status(input logic parity, input logic [7:0] cmd,
                                           input logic [7:0] addr, input logic [7:0] data,
                                           input logic [7:0] sum);
    logic [7:0] calc;
    calc = cmd + addr + data;
    if (parity)
      return STATUS_PARITY;
    else if (calc != sum)
      return STATUS_CSUM;
    else if (cmd != CMD_WR && cmd != CMD_RD)
      return STATUS_BAD_CMD;
    else
      return STATUS_OK;
  endfunction

endpackage

// File: rtl/uart_reg_bridge_resp_tx.sv
// Four-byte response serializer: header, status, rdata, checksum on AXI-Stream.
module uart_reg_bridge_resp_tx
  import uart_reg_bridge_pkg::*;
#(
  parameter logic [7:0] resp_header = 8'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  status_t    status,
  input  logic [7:0] rdata,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       done
);

  logic       busy;
  logic [1:0] idx;
  status_t    st_q;
  logic [7:0] rd_q;
  logic [7:0] byte_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      idx  <= 2'd0;
      st_q <= '0;
      rd_q <= '0;
    end else if (start) begin
      busy <= 1'b1;
      idx  <= 2'd0;
      st_q <= status;
      rd_q <= rdata;
    end else if (busy && m_axis_tready) begin
      idx <= idx + 2'd1;
      if (idx == 2'd3) busy <= 1'b0;
    end
  end

  always_comb begin
    byte_mux = resp_header;
    case (idx)
      2'd0: byte_mux = resp_header;
      2'd1: byte_mux = st_q;
      2'd2: byte_mux = rd_q;
      2'd3: byte_mux = st_q + rd_q;
      default: byte_mux = resp_header;
    endcase
  end

  assign m_axis_tvalid = busy;
  assign m_axis_tdata  = busy ? byte_mux : 8'h00;
  assign done          = busy && m_axis_tready && (idx == 2'd3);

endmodule

// File: rtl/uart_reg_bridge.sv
// Parses 5-byte command frames from the UART receive stream, performs a local
// register read or write, and returns a 4-byte response frame.
//
// state      | meaning
// HUNT       | discard bytes until a clean command header
// CMD..SUM   | collect frame bytes, inter-byte timeout armed
// EXEC       | register strobe issued when the frame is good
// RD_WAIT    | capture reg_rdata for a read
// RESP       | serializer sending the response frame
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int unsigned system_clk    = 50_000_000,
  parameter int unsigned band_rate     = 9600,
  parameter int unsigned timeout_bytes = 4,
  parameter logic [7:0]  cmd_header    = 8'hA5,
  parameter logic [7:0]  resp_header   = 8'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       timeout
);

  localparam int unsigned TIMEOUT_CYCLES = (system_clk / band_rate) * 11 * timeout_bytes;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic             run_q;
  logic [7:0]       cmd_q, addr_q, data_q;
  logic             parity_q;
  status_t          status_q;
  status_t          frame_st;
  logic [CNT_W-1:0] tmo_cnt;
  logic             in_rx, accept, tmo_hit, is_read;
  logic             resp_start, resp_done;
  logic [7:0]       resp_rdata;

  // run_q keeps tready low while reset is asserted and for the first cycle after.
  assign in_rx         = run_q && (state <= ST_SUM);
  assign s_axis_tready = in_rx;
  assign accept        = s_axis_tvalid && in_rx;
  assign tmo_hit       = in_rx && (state != ST_HUNT) && !accept && (tmo_cnt == '0);
  assign frame_st      = frame_status(parity_q | s_axis_tuser, cmd_q, addr_q, data_q, s_axis_tdata);
  assign is_read       = (status_q == STATUS_OK) && (cmd_q == CMD_RD);
  assign resp_start    = (state == ST_EXEC && !is_read) || (state == ST_RD_WAIT);
  assign resp_rdata    = (state == ST_RD_WAIT) ? reg_rdata :
                         (status_q == STATUS_OK) ? reg_wdata : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      run_q     <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      status_q  <= STATUS_OK;
      tmo_cnt   <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      timeout   <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      timeout   <= 1'b0;

      if (accept)
        tmo_cnt <= TMO_LOAD;
      else if (in_rx && state != ST_HUNT && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;

      case (state)
        ST_HUNT: begin
          if (accept && s_axis_tdata == cmd_header && !s_axis_tuser) begin
            state    <= ST_CMD;
            parity_q <= 1'b0;
          end
        end
        ST_CMD, ST_ADDR, ST_DATA: begin
          if (accept) begin
            parity_q <= parity_q | s_axis_tuser;
            if (state == ST_CMD)  cmd_q  <= s_axis_tdata;
            if (state == ST_ADDR) addr_q <= s_axis_tdata;
            if (state == ST_DATA) data_q <= s_axis_tdata;
            state <= state + 3'd1;
          end
        end
        ST_SUM: begin
          if (accept) begin
            status_q  <= frame_st;
            reg_addr  <= addr_q;
            reg_wdata <= data_q;
            reg_wr_en <= (frame_st == STATUS_OK) && (cmd_q == CMD_WR);
            reg_rd_en <= (frame_st == STATUS_OK) && (cmd_q == CMD_RD);
            state     <= ST_EXEC;
          end
        end
        ST_EXEC:    state <= is_read ? ST_RD_WAIT : ST_RESP;
        ST_RD_WAIT: state <= ST_RESP;
        ST_RESP:    if (resp_done) state <= ST_HUNT;
        default:    state <= ST_HUNT;
      endcase

      // A partial frame that stalls is dropped silently apart from the pulse.
      if (tmo_hit) begin
        timeout <= 1'b1;
        state   <= ST_HUNT;
      end
    end
  end

  uart_reg_bridge_resp_tx #(.resp_header(resp_header)) u_resp_tx (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (resp_start),
    .status        (status_q),
    .rdata         (resp_rdata),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .done          (resp_done)
  );

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Scoreboard bench for uart_reg_bridge: directed frames push expected strobes
// and response bytes; a monitor pops and compares as the DUT presents them.
module tb_uart_reg_bridge;

  localparam int TMO = (1000 / 100) * 11 * 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tuser = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       reg_wr_en, reg_rd_en;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       timeout;
  logic       rd_pend = 1'b0;
  logic [7:0] rd_val = 8'h77;

  uart_reg_bridge #(.system_clk(1000), .band_rate(100), .timeout_bytes(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Register port model: read data is only valid the cycle after reg_rd_en.
  always @(posedge clk) rd_pend <= reg_rd_en;
  assign reg_rdata = rd_pend ? rd_val : 8'h00;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } stb_t;

  logic [7:0] resp_q[$];
  int         lat_q[$];
  stb_t       stb_q[$];
  int         checks = 0, failures = 0;
  int         cyc = 0, acc_cyc = 0;
  int         tmo_seen = 0, tmo_cyc = 0;
  int         hs_in_frame = 0;
  logic       prev_valid = 1'b0;
  stb_t       mon_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (reg_wr_en || reg_rd_en) begin
        if (stb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_strobe actual wr=%b rd=%b required none", reg_wr_en, reg_rd_en);
        end else begin
          mon_s = stb_q.pop_front();
          check("strobe_wr", 32'(reg_wr_en), 32'(mon_s.wr));
          check("strobe_rd", 32'(reg_rd_en), 32'(!mon_s.wr));
          check("strobe_addr", 32'(reg_addr), 32'(mon_s.addr));
          if (mon_s.wr) check("strobe_wdata", 32'(reg_wdata), 32'(mon_s.wdata));
          check("strobe_cycle", 32'(cyc - acc_cyc), 32'd0);
        end
      end
      if (timeout) begin
        tmo_seen++;
        tmo_cyc = cyc;
      end
      if (m_tvalid && !prev_valid && lat_q.size() != 0)
        check("resp_latency", 32'(cyc - acc_cyc), 32'(lat_q.pop_front()));
      if (!m_tvalid && hs_in_frame != 0)
        check("resp_gap_valid", 32'(m_tvalid), 32'd1);
      if (m_tvalid && m_tready) begin
        if (resp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_byte actual=%0h required none", m_tdata);
        end else begin
          check("resp_byte", 32'(m_tdata), 32'(resp_q.pop_front()));
        end
        hs_in_frame = (hs_in_frame + 1) % 4;
      end
      prev_valid = m_tvalid;
    end
  end

  task automatic send(input logic [7:0] b, input logic u);
    int n;
    @(negedge clk);
    s_tdata = b; s_tuser = u; s_tvalid = 1'b1;
    n = 0;
    while (!s_tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL send_accept byte=%0h actual=stalled required=accepted", b);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    s_tvalid = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] s, input int par_idx);
    logic [7:0] f[5];
    f[0] = 8'hA5; f[1] = c; f[2] = a; f[3] = d; f[4] = s;
    for (int i = 0; i < 5; i++) send(f[i], i == par_idx);
  endtask

  task automatic expect_resp(input logic [7:0] st, input logic [7:0] rd, input int lat);
    resp_q.push_back(8'h5A);
    resp_q.push_back(st);
    resp_q.push_back(rd);
    resp_q.push_back(st + rd);
    lat_q.push_back(lat);
  endtask

  task automatic expect_stb(input logic wr, input logic [7:0] a, input logic [7:0] d);
    stb_t s;
    s.wr = wr; s.addr = a; s.wdata = d;
    stb_q.push_back(s);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || m_tvalid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++; failures++;
      $display("FAIL wait_idle actual=pending(%0d) required=drained", resp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_tready"}, 32'(s_tready), 32'd0);
    check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
    check({tag, "_m_tdata"}, 32'(m_tdata), 32'd0);
    check({tag, "_wr_en"}, 32'(reg_wr_en), 32'd0);
    check({tag, "_rd_en"}, 32'(reg_rd_en), 32'd0);
    check({tag, "_addr"}, 32'(reg_addr), 32'd0);
    check({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int t0, n;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write, then read, then the three error statuses and their priority.
    expect_stb(1'b1, 8'h10, 8'h3C); expect_resp(8'h00, 8'h3C, 1);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h4D, -1);
    wait_idle();
    check("addr_hold", 32'(reg_addr), 32'h10);
    check("wdata_hold", 32'(reg_wdata), 32'h3C);

    expect_stb(1'b0, 8'h20, 8'h00); expect_resp(8'h00, 8'h77, 2);
    send_frame(8'h02, 8'h20, 8'h00, 8'h22, -1);
    wait_idle();

    expect_resp(8'h01, 8'h00, 1);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h00, -1);
    wait_idle();
    expect_resp(8'h02, 8'h00, 1);
    send_frame(8'h07, 8'h10, 8'h00, 8'h17, -1);
    wait_idle();
    expect_resp(8'h03, 8'h00, 1);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h4D, 2);
    wait_idle();
    expect_resp(8'h03, 8'h00, 1);
    send_frame(8'h07, 8'h10, 8'h00, 8'h00, 3);
    wait_idle();
    expect_resp(8'h01, 8'h00, 1);
    send_frame(8'h07, 8'h10, 8'h00, 8'h00, -1);
    wait_idle();

    expect_stb(1'b1, 8'hFF, 8'h80); expect_resp(8'h00, 8'h80, 1);
    send_frame(8'h01, 8'hFF, 8'h80, 8'h80, -1);
    wait_idle();

    // Resync: parity-flagged header and junk are dropped.
    send(8'hA5, 1'b1);
    send(8'h01, 1'b0); send(8'h10, 1'b0); send(8'h3C, 1'b0); send(8'h4D, 1'b0);
    send(8'h00, 1'b0); send(8'hFF, 1'b0);
    expect_stb(1'b1, 8'h10, 8'h3C); expect_resp(8'h00, 8'h3C, 1);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h4D, -1);
    wait_idle();

    // Timeout of a partial frame, then normal operation.
    send(8'hA5, 1'b0); send(8'h01, 1'b0);
    t0 = acc_cyc;
    n = 0;
    while (tmo_seen == 0 && n < TMO + 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_count", 32'(tmo_seen), 32'd1);
    check("timeout_cycle", 32'(tmo_cyc - t0), 32'(TMO));
    repeat (3) @(negedge clk);
    check("timeout_hunt_ready", 32'(s_tready), 32'd1);
    expect_stb(1'b1, 8'h10, 8'h3C); expect_resp(8'h00, 8'h3C, 1);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h4D, -1);
    wait_idle();

    // A byte accepted on the expiry cycle keeps the frame alive.
    send(8'hA5, 1'b0); send(8'h01, 1'b0);
    t0 = acc_cyc;
    while (cyc < t0 + TMO - 2) @(negedge clk);
    expect_stb(1'b1, 8'h10, 8'h3C); expect_resp(8'h00, 8'h3C, 1);
    send(8'h10, 1'b0);
    check("expiry_byte_cycle", 32'(acc_cyc - t0), 32'(TMO));
    send(8'h3C, 1'b0); send(8'h4D, 1'b0);
    wait_idle();
    check("expiry_no_timeout", 32'(tmo_seen), 32'd1);

    // Backpressure on the first response byte with a second frame queued.
    m_tready = 1'b0;
    expect_stb(1'b1, 8'h10, 8'h3C); expect_resp(8'h00, 8'h3C, 1);
    expect_stb(1'b0, 8'h20, 8'h00); expect_resp(8'h00, 8'h77, 2);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h4D, -1);
    fork
      send_frame(8'h02, 8'h20, 8'h00, 8'h22, -1);
      begin
        n = 0;
        while (!m_tvalid && n < 20) begin
          @(negedge clk);
          n++;
        end
        repeat (10) begin
          @(negedge clk);
          #3;
          check("bp_tdata", 32'(m_tdata), 32'h5A);
          check("bp_s_tready", 32'(s_tready), 32'd0);
        end
        @(negedge clk);
        m_tready = 1'b1;
      end
    join
    wait_idle();

    // Reset while response byte 2 is presented.
    expect_stb(1'b1, 8'h10, 8'h3C); expect_resp(8'h00, 8'h3C, 1);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h4D, -1);
    n = 0;
    while (hs_in_frame != 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    m_tready = 1'b0;
    @(negedge clk);
    #3;
    check("pre_reset_tdata", 32'(m_tdata), 32'h3C);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midresp_reset");
    resp_q.delete();
    lat_q.delete();
    hs_in_frame = 0;
    prev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_tready = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_tvalid", 32'(m_tvalid), 32'd0);

    check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    check("strobe_queue_empty", 32'(stb_q.size()), 32'd0);
    check("timeout_total", 32'(tmo_seen), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
